// File: rtl/mem_port_arbiter.sv
// Two-requester memory port arbiter: data access (DM) has priority over instruction fetch (IF).
// Optional IF starvation guard is enabled by defining MEM_ARB_STARVE_GUARD_EN.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module mem_port_arbiter #(
    parameter int unsigned W          = `WORD_WIDTH,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         if_req,
    input  logic [W-1:0] if_addr,
    output logic [W-1:0] if_rdata,
    output logic         if_ack,
    input  logic         dm_req,
    input  logic         dm_we,
    input  logic [3:0]   dm_be,
    input  logic [W-1:0] dm_addr,
    input  logic [W-1:0] dm_wdata,
    output logic [W-1:0] dm_rdata,
    output logic         dm_ack,
    output logic         mem_req,
    output logic         mem_we,
    output logic [3:0]   mem_be,
    output logic [W-1:0] mem_addr,
    output logic [W-1:0] mem_wdata,
    input  logic [W-1:0] mem_rdata,
    input  logic         mem_ack,
    output logic         busy
);

    typedef enum logic [2:0] {
        IDLE,
        IF_BUSY,
        DM_BUSY,
        IF_RESP,
        DM_RESP
    } state_t;

    state_t       state, state_nxt;
    logic         mem_req_nxt;
    logic         mem_we_nxt;
    logic [3:0]   mem_be_nxt;
    logic [W-1:0] mem_addr_nxt;
    logic [W-1:0] mem_wdata_nxt;
    logic [W-1:0] if_rdata_nxt;
    logic [W-1:0] dm_rdata_nxt;
    logic         grant_dm;
    logic         grant_if;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int unsigned CW =
        ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    logic [CW-1:0] starve_cnt;
    logic          starve_force;

    // IF overrides DM only once DM has won STARVE_MAX times in a row while IF waited
    assign starve_force = if_req && (starve_cnt == STARVE_LIM);
    assign grant_dm     = dm_req && !starve_force;
    assign grant_if     = if_req && !grant_dm;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (grant_dm) begin
                starve_cnt <= if_req ? starve_cnt + 1'b1 : '0;
            end else if (grant_if) begin
                starve_cnt <= '0;
            end
        end
    end
`else
    assign grant_dm = dm_req;
    assign grant_if = if_req && !dm_req;
`endif

    always_comb begin
        state_nxt     = state;
        mem_req_nxt   = mem_req;
        mem_we_nxt    = mem_we;
        mem_be_nxt    = mem_be;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        if_rdata_nxt  = if_rdata;
        dm_rdata_nxt  = dm_rdata;

        case (state)
            IDLE: begin
                if (grant_dm) begin
                    mem_req_nxt   = 1'b1;
                    mem_we_nxt    = dm_we;
                    mem_be_nxt    = dm_be;
                    mem_addr_nxt  = dm_addr;
                    mem_wdata_nxt = dm_wdata;
                    state_nxt     = DM_BUSY;
                end else if (grant_if) begin
                    mem_req_nxt   = 1'b1;
                    mem_we_nxt    = 1'b0;
                    mem_be_nxt    = '1;
                    mem_addr_nxt  = if_addr;
                    mem_wdata_nxt = '0;
                    state_nxt     = IF_BUSY;
                end else begin
                    mem_req_nxt   = 1'b0;
                end
            end
            IF_BUSY: begin
                if (mem_req && mem_ack) begin
                    mem_req_nxt  = 1'b0;
                    mem_we_nxt   = 1'b0;
                    if_rdata_nxt = mem_rdata;
                    state_nxt    = IF_RESP;
                end
            end
            DM_BUSY: begin
                if (mem_req && mem_ack) begin
                    mem_req_nxt = 1'b0;
                    mem_we_nxt  = 1'b0;
                    // stores complete without disturbing the last load value
                    if (!mem_we) begin
                        dm_rdata_nxt = mem_rdata;
                    end
                    state_nxt   = DM_RESP;
                end
            end
            IF_RESP: state_nxt = IDLE;
            DM_RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            state     <= state_nxt;
            mem_req   <= mem_req_nxt;
            mem_we    <= mem_we_nxt;
            mem_be    <= mem_be_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            if_rdata  <= if_rdata_nxt;
            dm_rdata  <= dm_rdata_nxt;
        end
    end

    assign if_ack = (state == IF_RESP);
    assign dm_ack = (state == DM_RESP);
    assign busy   = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; expectations follow the
// MEM_ARB_STARVE_GUARD_EN setting of the build.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    mem_port_arbiter #(.W(32), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0; if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_be = '0; dm_addr = '0; dm_wdata = '0;
        mem_rdata = '0; mem_ack = 1'b0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_if_ack", if_ack, 0);
        chk("rst_dm_ack", dm_ack, 0);
        rst = 1'b1;
        tick();

        // 1: single fetch, memory acks in the second mem_req cycle
        if_req = 1'b1; if_addr = 32'h0040_0000;
        tick();
        chk("t1_mem_req", mem_req, 1);
        chk("t1_mem_addr", mem_addr, 32'h0040_0000);
        chk("t1_mem_we", mem_we, 0);
        chk("t1_mem_be", mem_be, 4'hF);
        chk("t1_busy", busy, 1);
        chk("t1_if_ack_early0", if_ack, 0);
        tick();
        chk("t1_if_ack_early1", if_ack, 0);
        mem_ack = 1'b1; mem_rdata = 32'h8C08_0004;
        tick();
        chk("t1_if_ack", if_ack, 1);
        chk("t1_if_rdata", if_rdata, 32'h8C08_0004);
        chk("t1_mem_req_drop", mem_req, 0);
        if_req = 1'b0; mem_ack = 1'b0;
        tick();
        chk("t1_if_ack_once", if_ack, 0);
        chk("t1_busy_idle", busy, 0);

        // 2: simultaneous requests, store wins, fetch follows after one IDLE cycle
        if_req = 1'b1; if_addr = 32'h0040_0004;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h1001_0000;
        dm_wdata = 32'hDEAD_BEEF; dm_be = 4'b0011;
        tick();
        chk("t2_mem_we", mem_we, 1);
        chk("t2_mem_addr", mem_addr, 32'h1001_0000);
        chk("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("t2_mem_be", mem_be, 4'b0011);
        mem_ack = 1'b1; mem_rdata = 32'hAAAA_5555;
        tick();
        chk("t2_dm_ack", dm_ack, 1);
        chk("t2_if_ack", if_ack, 0);
        chk("t2_dm_rdata_kept", dm_rdata, 32'h0);
        dm_req = 1'b0; dm_we = 1'b0; mem_ack = 1'b0;
        tick();
        chk("t2_idle_gap_busy", busy, 0);
        chk("t2_idle_gap_req", mem_req, 0);
        tick();
        chk("t2_if_mem_req", mem_req, 1);
        chk("t2_if_mem_addr", mem_addr, 32'h0040_0004);
        chk("t2_if_mem_we", mem_we, 0);
        chk("t2_if_mem_be", mem_be, 4'hF);
        chk("t2_if_mem_wdata", mem_wdata, 32'h0);
        mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
        tick();
        chk("t2_if_ack", if_ack, 1);
        chk("t2_if_rdata", if_rdata, 32'h1111_2222);
        if_req = 1'b0; mem_ack = 1'b0;
        tick();

        // 3: zero-wait load
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h1001_0010; dm_be = 4'hF;
        tick();
        chk("t3_mem_req", mem_req, 1);
        chk("t3_dm_ack_early", dm_ack, 0);
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        tick();
        chk("t3_mem_req_1cyc", mem_req, 0);
        chk("t3_dm_ack", dm_ack, 1);
        chk("t3_dm_rdata", dm_rdata, 32'h1234_5678);
        dm_req = 1'b0; mem_ack = 1'b0;
        tick();
        chk("t3_dm_ack_once", dm_ack, 0);

        // 4: asynchronous reset during DM_BUSY
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h1001_0020;
        dm_wdata = 32'h55AA_55AA; dm_be = 4'hF;
        tick();
        chk("t4_pre_mem_req", mem_req, 1);
        #2 rst = 1'b0;
        #1;
        chk("t4_async_mem_req", mem_req, 0);
        chk("t4_async_mem_we", mem_we, 0);
        chk("t4_async_mem_be", mem_be, 0);
        chk("t4_async_mem_addr", mem_addr, 0);
        chk("t4_async_mem_wdata", mem_wdata, 0);
        chk("t4_async_dm_rdata", dm_rdata, 0);
        chk("t4_async_if_rdata", if_rdata, 0);
        chk("t4_async_busy", busy, 0);
        chk("t4_async_dm_ack", dm_ack, 0);
        dm_req = 1'b0; dm_we = 1'b0; mem_ack = 1'b1;
        tick(); tick();
        rst = 1'b1;
        tick();
        chk("t4_post_busy", busy, 0);
        chk("t4_post_dm_ack0", dm_ack, 0);
        mem_ack = 1'b0;
        tick();
        chk("t4_post_dm_ack1", dm_ack, 0);
        chk("t4_post_mem_req", mem_req, 0);

        // 5: DM request arriving while a fetch is in flight
        if_req = 1'b1; if_addr = 32'h0040_0100;
        tick();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h1001_0040; dm_be = 4'hF;
        tick();
        chk("t5_hold_addr0", mem_addr, 32'h0040_0100);
        chk("t5_hold_we0", mem_we, 0);
        tick();
        chk("t5_hold_addr1", mem_addr, 32'h0040_0100);
        mem_ack = 1'b1; mem_rdata = 32'h0000_ABCD;
        tick();
        chk("t5_if_ack", if_ack, 1);
        chk("t5_dm_ack_none", dm_ack, 0);
        if_req = 1'b0; mem_ack = 1'b0;
        tick();
        chk("t5_idle", busy, 0);
        tick();
        chk("t5_dm_mem_req", mem_req, 1);
        chk("t5_dm_mem_addr", mem_addr, 32'h1001_0040);
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
        tick();
        chk("t5_dm_ack", dm_ack, 1);
        chk("t5_dm_rdata", dm_rdata, 32'h0BAD_F00D);
        dm_req = 1'b0; mem_ack = 1'b0;
        tick();

        // 6: DM held high with IF waiting; memory always acks at once
        if_req = 1'b1; if_addr = 32'h0040_0200;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h1001_0080; dm_be = 4'hF;
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_0001;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_dm_grant_addr", mem_addr, 32'h1001_0080);
            tick();
            chk("t6_dm_ack", dm_ack, 1);
            tick();
            chk("t6_idle", busy, 0);
        end
        tick();
`ifdef MEM_ARB_STARVE_GUARD_EN
        chk("t6_guard_if_grant", mem_addr, 32'h0040_0200);
        tick();
        chk("t6_guard_if_ack", if_ack, 1);
        if_req = 1'b0;
        tick();
        tick();
        chk("t6_guard_dm_again", mem_addr, 32'h1001_0080);
        dm_req = 1'b0;
        tick();
        mem_ack = 1'b0;
        tick();
`else
        chk("t6_strict_dm_grant", mem_addr, 32'h1001_0080);
        tick();
        chk("t6_strict_dm_ack", dm_ack, 1);
        dm_req = 1'b0;
        tick();
        tick();
        chk("t6_strict_if_grant", mem_addr, 32'h0040_0200);
        tick();
        chk("t6_strict_if_ack", if_ack, 1);
        if_req = 1'b0; mem_ack = 1'b0;
        tick();
`endif
        chk("t6_final_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
